// File: rtl/shim_integrator_pkg.sv
// -----------------------------------------------------------------------------
// shim_integrator_pkg
//   Shared types and elaboration-time helpers for the rolling-window shim
//   integrator: control state encoding, width derivation for chunk sums and
//   window totals, and a constant clog2.
// -----------------------------------------------------------------------------
package shim_integrator_pkg;

   // Width of the chunk_shift configuration port.
   localparam int SHIFT_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RUNNING = 3'd3,
      ST_TRIPPED = 3'd4,
      ST_CFG_ERR = 3'd5
   } state_t;

   // Smallest w such that 2**w >= value.
   function automatic int clog2_f(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // A chunk holds at most 2**max_shift samples of sample_w bits.
   function automatic int chunk_w_f(input int sample_w, input int max_shift);
      return sample_w + max_shift;
   endfunction

   // A window holds 2**chunk_aw chunks.
   function automatic int tot_w_f(input int sample_w, input int max_shift, input int chunk_aw);
      return sample_w + max_shift + chunk_aw;
   endfunction

endpackage

// File: rtl/shim_window_integrator_n_ring.sv
// -----------------------------------------------------------------------------
// shim_chunk_ring
//   Simple dual-port RAM holding the last CHUNKS chunk sums of all channels.
//   One write port, one read port with a registered (1-cycle) read. Contents
//   are not reset; the integrator tracks validity with its own fill counter.
//   The integrator never reads and writes the same address in one cycle, so
//   no read-during-write behaviour is defined.
// Ports
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data (all channels concatenated)
//   i_re     in   read enable
//   i_raddr  in   read address
//   o_rdata  out  registered read data, valid the cycle after i_re
// -----------------------------------------------------------------------------
module shim_chunk_ring #(
   parameter int WIDTH = 8,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Write port.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/shim_window_integrator_n.sv
// -----------------------------------------------------------------------------
// shim_window_integrator_n
//   Rolling-window |sample| integrator for N_CH shim channels. Samples are
//   decimated by DECIM, summed into chunks of 2**chunk_shift samples, and the
//   last CHUNKS chunk sums per channel are kept in a ring RAM. A running window
//   total per channel is maintained incrementally (add newest chunk, subtract
//   the chunk it replaces). At each chunk boundary an enabled channel whose
//   total exceeds threshold_average * window length trips the block.
// Ports
//   clk                clock
//   resetn             synchronous active-low reset
//   enable             rising edge in IDLE latches config and starts setup
//   clear              pulse: back to IDLE, sums/flags zeroed
//   chunk_shift        log2(samples per chunk)
//   threshold_average  mean |sample| limit
//   ch_enable          per-channel compare enable
//   sample_core_done   sample core ready, releases WAIT
//   abs_sample_concat  channel i at [(i+1)*SAMPLE_W-1 -: SAMPLE_W]
//   setup_done         high from RUNNING entry until reset/clear
//   window_full        high once CHUNKS chunks have been written
//   over_thresh        sticky trip flag
//   over_thresh_mask   sticky per-channel trip pattern
//   err_config         sticky, chunk_shift above MAX_SHIFT
// -----------------------------------------------------------------------------
module shim_window_integrator_n
   import shim_integrator_pkg::*;
#(
   parameter int N_CH      = 8,
   parameter int SAMPLE_W  = 15,
   parameter int DECIM     = 16,
   parameter int CHUNK_AW  = 6,
   parameter int MAX_SHIFT = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic                       clear,
   input  logic [SHIFT_W-1:0]         chunk_shift,
   input  logic [SAMPLE_W-1:0]        threshold_average,
   input  logic [N_CH-1:0]            ch_enable,
   input  logic                       sample_core_done,
   input  logic [N_CH*SAMPLE_W-1:0]   abs_sample_concat,
   output logic                       setup_done,
   output logic                       window_full,
   output logic                       over_thresh,
   output logic [N_CH-1:0]            over_thresh_mask,
   output logic                       err_config
);

   localparam int CHUNK_W = chunk_w_f(SAMPLE_W, MAX_SHIFT);
   localparam int TOT_W   = tot_w_f(SAMPLE_W, MAX_SHIFT, CHUNK_AW);
   localparam int CHUNKS  = 1 << CHUNK_AW;
   localparam int DEC_W   = clog2_f(DECIM);
   localparam int IDX_W   = MAX_SHIFT;

   localparam logic [DEC_W-1:0]    DEC_LAST    = DEC_W'(DECIM - 1);
   localparam logic [CHUNK_AW:0]   FILL_MAX    = (CHUNK_AW + 1)'(CHUNKS);
   localparam logic [CHUNK_AW:0]   FILL_LAST   = (CHUNK_AW + 1)'(CHUNKS - 1);
   localparam logic [SHIFT_W-1:0]  MAX_SHIFT_L = SHIFT_W'(MAX_SHIFT);
   localparam logic [SHIFT_W:0]    CHUNK_AW_L  = (SHIFT_W + 1)'(CHUNK_AW);

   // Control state
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_enable_d;

   // Latched configuration
   logic [SHIFT_W-1:0]     r_shift;
   logic [SAMPLE_W-1:0]    r_thr;
   logic [N_CH-1:0]        r_ch_en;
   logic [TOT_W-1:0]       r_limit;

   // Sample / chunk timing
   logic [DEC_W-1:0]       r_dec_cnt;
   logic [IDX_W-1:0]       r_smp_idx;
   logic                   r_e1;
   logic                   r_e2;

   // Ring bookkeeping
   logic [CHUNK_AW-1:0]    r_wr_ptr;
   logic [CHUNK_AW:0]      r_fill;

   // Registered outputs
   logic                   r_setup_done;
   logic                   r_window_full;
   logic                   r_over_thresh;
   logic [N_CH-1:0]        r_over_mask;
   logic                   r_err_config;

   // Combinational control
   logic                   w_en_rise;
   logic                   w_cfg_bad;
   logic                   w_latch_cfg;
   logic                   w_start_run;
   logic                   w_tick;
   logic                   w_chunk_end;
   logic                   w_ring_full;
   logic                   w_trip;
   logic [N_CH-1:0]        w_hit;
   logic [SHIFT_W:0]       w_limit_shamt;
   logic [TOT_W-1:0]       w_limit;
   logic [IDX_W:0]         w_idx_last;
   logic [N_CH*CHUNK_W-1:0] w_ring_wdata;
   logic [N_CH*CHUNK_W-1:0] w_ring_rdata;

   assign w_en_rise   = enable & ~r_enable_d;
   assign w_cfg_bad   = (r_state == ST_IDLE) & w_en_rise & (chunk_shift > MAX_SHIFT_L);
   assign w_latch_cfg = (r_state == ST_IDLE) & w_en_rise & ~(chunk_shift > MAX_SHIFT_L);
   assign w_start_run = (r_state == ST_WAIT) & sample_core_done;
   assign w_tick      = (r_state == ST_RUNNING) & (r_dec_cnt == DEC_LAST);
   assign w_ring_full = (r_fill == FILL_MAX);
   assign w_trip      = (r_state == ST_RUNNING) & r_e2 & (|w_hit);

   // Window limit = threshold * 2**chunk_shift * CHUNKS, done as a shift.
   assign w_limit_shamt = {1'b0, r_shift} + CHUNK_AW_L;
   assign w_limit       = TOT_W'(r_thr) << w_limit_shamt;

   // Index of the last sample in a chunk: 2**chunk_shift - 1.
   assign w_idx_last  = ((IDX_W + 1)'(1) << r_shift) - (IDX_W + 1)'(1);
   assign w_chunk_end = w_tick & ({1'b0, r_smp_idx} == w_idx_last);

   // Enable edge detector; runs through clear so a held-high enable does not re-arm.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_enable_d <= 1'b0;
      end else begin
         r_enable_d <= enable;
      end
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cfg_bad) begin
               w_state_nxt = ST_CFG_ERR;
            end else if (w_latch_cfg) begin
               w_state_nxt = ST_SETUP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sample_core_done) begin
               w_state_nxt = ST_RUNNING;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_RUNNING: begin
            if (w_trip) begin
               w_state_nxt = ST_TRIPPED;
            end else begin
               w_state_nxt = ST_RUNNING;
            end
         end
         ST_TRIPPED: begin
            w_state_nxt = ST_TRIPPED;
         end
         ST_CFG_ERR: begin
            w_state_nxt = ST_CFG_ERR;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Config latch, limit, decimation/chunk counters, chunk-end pipeline and ring pointers.
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         r_shift   <= '0;
         r_thr     <= '0;
         r_ch_en   <= '0;
         r_limit   <= '0;
         r_dec_cnt <= '0;
         r_smp_idx <= '0;
         r_e1      <= 1'b0;
         r_e2      <= 1'b0;
         r_wr_ptr  <= '0;
         r_fill    <= '0;
      end else begin
         if (w_latch_cfg) begin
            r_shift <= chunk_shift;
            r_thr   <= threshold_average;
            r_ch_en <= ch_enable;
         end
         if (r_state == ST_SETUP) begin
            r_limit <= w_limit;
         end
         if (w_start_run) begin
            r_dec_cnt <= '0;
            r_smp_idx <= '0;
         end else if (r_state == ST_RUNNING) begin
            r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + DEC_W'(1);
            if (w_tick) begin
               r_smp_idx <= w_chunk_end ? '0 : r_smp_idx + IDX_W'(1);
            end
         end
         // E+1 / E+2 strobes follow a chunk end.
         r_e1 <= w_chunk_end;
         r_e2 <= r_e1;
         if (r_e1) begin
            r_wr_ptr <= r_wr_ptr + CHUNK_AW'(1);
            if (!w_ring_full) begin
               r_fill <= r_fill + (CHUNK_AW + 1)'(1);
            end
         end
      end
   end

   // Sticky status outputs.
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         r_setup_done  <= 1'b0;
         r_window_full <= 1'b0;
         r_over_thresh <= 1'b0;
         r_over_mask   <= '0;
         r_err_config  <= 1'b0;
      end else begin
         if (w_start_run) begin
            r_setup_done <= 1'b1;
         end
         if (r_e1 && (r_fill == FILL_LAST)) begin
            r_window_full <= 1'b1;
         end
         if (w_trip) begin
            r_over_thresh <= 1'b1;
            r_over_mask   <= w_hit;
         end
         if (w_cfg_bad) begin
            r_err_config <= 1'b1;
         end
      end
   end

   // Per-channel chunk accumulator, window total and compare.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SAMPLE_W-1:0] w_smp;
      logic [CHUNK_W-1:0]  w_acc_sum;
      logic [CHUNK_W-1:0]  w_oldest;
      logic [CHUNK_W-1:0]  r_acc;
      logic [CHUNK_W-1:0]  r_final;
      logic [TOT_W-1:0]    r_total;

      assign w_smp     = abs_sample_concat[(i + 1) * SAMPLE_W - 1 -: SAMPLE_W];
      assign w_acc_sum = r_acc + CHUNK_W'(w_smp);
      // The slot being overwritten only holds a real chunk once the ring is full.
      assign w_oldest  = w_ring_full ? w_ring_rdata[i * CHUNK_W +: CHUNK_W] : '0;
      assign w_ring_wdata[i * CHUNK_W +: CHUNK_W] = r_final;
      assign w_hit[i]  = r_ch_en[i] & (r_total > r_limit);

      // Accumulate samples; on chunk end hand the sum to the window stage.
      always_ff @(posedge clk) begin
         if (!resetn || clear) begin
            r_acc   <= '0;
            r_final <= '0;
            r_total <= '0;
         end else begin
            if (w_tick) begin
               if (w_chunk_end) begin
                  r_final <= w_acc_sum;
                  r_acc   <= '0;
               end else begin
                  r_acc <= w_acc_sum;
               end
            end
            // Oldest chunk was added earlier, so the difference never underflows.
            if (r_e1) begin
               r_total <= r_total + TOT_W'(r_final) - TOT_W'(w_oldest);
            end
         end
      end
   end

   // Read the slot about to be overwritten at E, write the new chunk at E+1.
   shim_chunk_ring #(
      .WIDTH (N_CH * CHUNK_W),
      .AW    (CHUNK_AW)
   ) u_ring (
      .clk     (clk),
      .i_we    (r_e1),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_ring_wdata),
      .i_re    (w_chunk_end),
      .i_raddr (r_wr_ptr),
      .o_rdata (w_ring_rdata)
   );

   assign setup_done       = r_setup_done;
   assign window_full      = r_window_full;
   assign over_thresh      = r_over_thresh;
   assign over_thresh_mask = r_over_mask;
   assign err_config       = r_err_config;

endmodule
